// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the incoming operation; stage 2 registers the computed
// result and status flags. A single enable stalls both stages together
// whenever the output holds a result that downstream has not yet taken.
module alu_pipe #(
    parameter int WIDTH    = 8,
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Stage 1: captured operation
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_op_reg;

    // Stage 2: result and flags presented downstream
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic             out_carry_reg;
    logic             out_ovf_reg;
    logic             out_zero_reg;
    logic             out_neg_reg;

    // Computed values for the operation sitting in stage 1
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             ovf_next;

    // Wide intermediates: the extra bit carries out the carry/borrow or the
    // last bit shifted out, so no separate index arithmetic is needed.
    logic [WIDTH:0]   sum_full;
    logic [WIDTH:0]   diff_full;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH:0]   shr_full;
    logic [SH_W-1:0]  sh_amt;

    logic en;

    // Whole pipe advances unless a finished result is waiting on downstream
    assign en        = !out_valid_reg || out_ready;
    assign in_ready  = en && !rst;

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_carry  = out_carry_reg;
    assign out_ovf    = out_ovf_reg;
    assign out_zero   = out_zero_reg;
    assign out_neg    = out_neg_reg;

    // Datapath: evaluate every operation and select by opcode
    always_comb begin
        sh_amt      = s1_b_reg[SH_W-1:0];
        sum_full    = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
        diff_full   = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
        shl_full    = {1'b0, s1_a_reg} << sh_amt;
        shr_full    = {s1_a_reg, 1'b0} >> sh_amt;
        result_next = '0;
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
        case (s1_op_reg)
            OP_ADD: begin
                result_next = sum_full[WIDTH-1:0];
                carry_next  = sum_full[WIDTH];
                ovf_next    = (s1_a_reg[WIDTH-1] == s1_b_reg[WIDTH-1]) &&
                              (sum_full[WIDTH-1] != s1_a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                result_next = diff_full[WIDTH-1:0];
                carry_next  = diff_full[WIDTH];
                ovf_next    = (s1_a_reg[WIDTH-1] != s1_b_reg[WIDTH-1]) &&
                              (diff_full[WIDTH-1] != s1_a_reg[WIDTH-1]);
            end
            OP_AND: result_next = s1_a_reg & s1_b_reg;
            OP_OR:  result_next = s1_a_reg | s1_b_reg;
            OP_XOR: result_next = s1_a_reg ^ s1_b_reg;
            OP_NOT: result_next = ~s1_a_reg;
            OP_SHL: begin
                if (SHIFT_EN) begin
                    result_next = shl_full[WIDTH-1:0];
                    carry_next  = shl_full[WIDTH];
                end
            end
            OP_SHR: begin
                if (SHIFT_EN) begin
                    result_next = shr_full[WIDTH:1];
                    carry_next  = shr_full[0];
                end
            end
            default: begin
                result_next = '0;
            end
        endcase
    end

    // Pipeline registers; bubbles clear stage 2 so no stale data is shown
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
            s1_op_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_carry_reg  <= 1'b0;
            out_ovf_reg    <= 1'b0;
            out_zero_reg   <= 1'b0;
            out_neg_reg    <= 1'b0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s1_a_reg      <= op_a;
            s1_b_reg      <= op_b;
            s1_op_reg     <= alu_op;
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg <= result_next;
                out_carry_reg  <= carry_next;
                out_ovf_reg    <= ovf_next;
                out_zero_reg   <= (result_next == '0);
                out_neg_reg    <= result_next[WIDTH-1];
            end else begin
                out_result_reg <= '0;
                out_carry_reg  <= 1'b0;
                out_ovf_reg    <= 1'b0;
                out_zero_reg   <= 1'b0;
                out_neg_reg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH=8). A second instance with shifts
// disabled shares the same inputs to cover the SHIFT_EN=0 behaviour.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] alu_op;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_result;
    logic       out_carry, out_ovf, out_zero, out_neg;

    logic       ns_in_ready;
    logic       ns_out_valid;
    logic [7:0] ns_out_result;
    logic       ns_out_carry, ns_out_ovf, ns_out_zero, ns_out_neg;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .SHIFT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
    );

    alu_pipe #(.WIDTH(8), .SHIFT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
        .out_valid(ns_out_valid), .out_ready(out_ready), .out_result(ns_out_result),
        .out_carry(ns_out_carry), .out_ovf(ns_out_ovf), .out_zero(ns_out_zero), .out_neg(ns_out_neg)
    );

    // Packed view {valid, result, carry, ovf, zero, neg}
    function automatic logic [12:0] obs();
        return {out_valid, out_result, out_carry, out_ovf, out_zero, out_neg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle, then idle one cycle; result is then on the outputs
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid  = 1'b1;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; alu_op = '0; out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        tests_run++;
        if (obs() !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h want=%h", obs(), 13'h0);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
        end
        $display("[TB] reset checked");
    endtask

    // Table-driven single-op checks: op, a, b, expected {valid,res,c,v,z,n}
    task automatic test_ops();
        logic [2:0]  t_op  [15];
        logic [7:0]  t_a   [15];
        logic [7:0]  t_b   [15];
        logic [12:0] t_exp [15];
        t_op[0]  = 3'b000; t_a[0]  = 8'hFF; t_b[0]  = 8'h01; t_exp[0]  = {1'b1, 8'h00, 4'b1010};
        t_op[1]  = 3'b000; t_a[1]  = 8'h7F; t_b[1]  = 8'h01; t_exp[1]  = {1'b1, 8'h80, 4'b0101};
        t_op[2]  = 3'b001; t_a[2]  = 8'h80; t_b[2]  = 8'h01; t_exp[2]  = {1'b1, 8'h7F, 4'b0100};
        t_op[3]  = 3'b001; t_a[3]  = 8'h01; t_b[3]  = 8'h02; t_exp[3]  = {1'b1, 8'hFF, 4'b1001};
        t_op[4]  = 3'b010; t_a[4]  = 8'hF0; t_b[4]  = 8'h3C; t_exp[4]  = {1'b1, 8'h30, 4'b0000};
        t_op[5]  = 3'b011; t_a[5]  = 8'h0F; t_b[5]  = 8'hA0; t_exp[5]  = {1'b1, 8'hAF, 4'b0001};
        t_op[6]  = 3'b100; t_a[6]  = 8'hFF; t_b[6]  = 8'h0F; t_exp[6]  = {1'b1, 8'hF0, 4'b0001};
        t_op[7]  = 3'b101; t_a[7]  = 8'h55; t_b[7]  = 8'h12; t_exp[7]  = {1'b1, 8'hAA, 4'b0001};
        t_op[8]  = 3'b101; t_a[8]  = 8'hFF; t_b[8]  = 8'h00; t_exp[8]  = {1'b1, 8'h00, 4'b0010};
        t_op[9]  = 3'b110; t_a[9]  = 8'h81; t_b[9]  = 8'h01; t_exp[9]  = {1'b1, 8'h02, 4'b1000};
        t_op[10] = 3'b111; t_a[10] = 8'h81; t_b[10] = 8'h00; t_exp[10] = {1'b1, 8'h81, 4'b0001};
        t_op[11] = 3'b111; t_a[11] = 8'h81; t_b[11] = 8'h01; t_exp[11] = {1'b1, 8'h40, 4'b1000};
        t_op[12] = 3'b110; t_a[12] = 8'h81; t_b[12] = 8'h09; t_exp[12] = {1'b1, 8'h02, 4'b1000};
        t_op[13] = 3'b110; t_a[13] = 8'h01; t_b[13] = 8'h07; t_exp[13] = {1'b1, 8'h80, 4'b0001};
        t_op[14] = 3'b111; t_a[14] = 8'h80; t_b[14] = 8'h07; t_exp[14] = {1'b1, 8'h01, 4'b0000};
        for (int i = 0; i < 15; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            $display("[TB] op=%b a=%h b=%h -> %h", t_op[i], t_a[i], t_b[i], obs());
            tests_run++;
            if (obs() !== t_exp[i]) begin
                tests_failed++;
                $display("FAIL op_vec%0d got=%h want=%h", i, obs(), t_exp[i]);
            end
        end
    endtask

    task automatic test_shift_disabled();
        logic [12:0] ns_obs;
        issue(3'b110, 8'h81, 8'h01);
        ns_obs = {ns_out_valid, ns_out_result, ns_out_carry, ns_out_ovf, ns_out_zero, ns_out_neg};
        $display("[TB] noshift SHL 81 sh=1 -> %h", ns_obs);
        tests_run++;
        if (ns_obs !== {1'b1, 8'h00, 4'b0010}) begin
            tests_failed++;
            $display("FAIL noshift_shl got=%h want=%h", ns_obs, {1'b1, 8'h00, 4'b0010});
        end
        issue(3'b111, 8'hF0, 8'h02);
        ns_obs = {ns_out_valid, ns_out_result, ns_out_carry, ns_out_ovf, ns_out_zero, ns_out_neg};
        $display("[TB] noshift SHR F0 sh=2 -> %h", ns_obs);
        tests_run++;
        if (ns_obs !== {1'b1, 8'h00, 4'b0010}) begin
            tests_failed++;
            $display("FAIL noshift_shr got=%h want=%h", ns_obs, {1'b1, 8'h00, 4'b0010});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] b_op [4];
        logic [7:0] b_a  [4];
        logic [7:0] b_b  [4];
        logic [7:0] b_r  [4];
        b_op[0] = 3'b000; b_a[0] = 8'h01; b_b[0] = 8'h02; b_r[0] = 8'h03;
        b_op[1] = 3'b000; b_a[1] = 8'h03; b_b[1] = 8'h04; b_r[1] = 8'h07;
        b_op[2] = 3'b100; b_a[2] = 8'h0F; b_b[2] = 8'hFF; b_r[2] = 8'hF0;
        b_op[3] = 3'b001; b_a[3] = 8'h10; b_b[3] = 8'h01; b_r[3] = 8'h0F;
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = b_op[0]; op_a = b_a[0]; op_b = b_b[0];
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0 || k == 5) begin
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_idle%0d got=%b want=0", k, out_valid);
                end
            end else begin
                $display("[TB] b2b result%0d = %h valid=%b", k - 1, out_result, out_valid);
                tests_run++;
                if ({out_valid, out_result} !== {1'b1, b_r[k-1]}) begin
                    tests_failed++;
                    $display("FAIL b2b_res%0d got=%b/%h want=1/%h", k - 1, out_valid, out_result, b_r[k-1]);
                end
            end
            if (k < 3) begin
                alu_op = b_op[k+1]; op_a = b_a[k+1]; op_b = b_b[k+1];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] expq[$];
        logic [7:0] snap;
        logic [7:0] want;
        int sent = 0;
        int recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 6);
            alu_op    = 3'b000;
            op_a      = 8'(sent);
            op_b      = 8'(8'h10 * sent);
            #1;
            if (c == 3) snap = out_result;
            if (c >= 3 && c <= 5) begin
                tests_run++;
                if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, snap}) begin
                    tests_failed++;
                    $display("FAIL stall_c%0d got ready=%b valid=%b res=%h want ready=0 valid=1 res=%h",
                             c, in_ready, out_valid, out_result, snap);
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(8'(sent * 8'h11));
                sent++;
            end
            if (out_valid && out_ready) begin
                want = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                $display("[TB] stall recv%0d = %h", recv, out_result);
                tests_run++;
                if (out_result !== want) begin
                    tests_failed++;
                    $display("FAIL stall_order%0d got=%h want=%h", recv, out_result, want);
                end
                recv++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (recv !== 6 || expq.size() !== 0) begin
            tests_failed++;
            $display("FAIL stall_count got=%0d pending=%0d want=6 pending=0", recv, expq.size());
        end
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_dup got valid=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 3'b011; op_a = 8'h12; op_b = 8'h40;
        tick();
        alu_op = 3'b000; op_a = 8'h20; op_b = 8'h22;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_flight_ready got=%b want=0", in_ready);
        end
        tick();
        $display("[TB] reset in flight -> %h", obs());
        tests_run++;
        if (obs() !== 13'h0) begin
            tests_failed++;
            $display("FAIL rst_flight_out got=%h want=%h", obs(), 13'h0);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (obs() !== 13'h0) begin
                tests_failed++;
                $display("FAIL rst_flight_stale%0d got=%h want=%h", k, obs(), 13'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_shift_disabled();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
